// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;
    localparam int IMEM_DEPTH     = 257;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader uses the master view, the host bridge and memory the slave view.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        WE_IM;
    logic [31:0] A_IM_W;
    logic [31:0] WD_IM;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output WE_IM,
        output A_IM_W,
        output WD_IM
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  WE_IM,
        input  A_IM_W,
        input  WD_IM
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects bytes LSB first into one word; word_full marks the byte that completes it.
module word_assembler
    import imem_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_full
);
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;

    always_comb begin
        lane_d = lane_q;
        if (clr) begin
            lane_d = '0;
        end else if (byte_valid) begin
            lane_d = lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign word_full = byte_valid && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        logic [7:0] byte_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                byte_q <= '0;
            end else if (byte_valid && (lane_q == LANE_W'(gi))) begin
                byte_q <= byte_data;
            end
        end

        assign word[gi*8 +: 8] = byte_q;
    end
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, holding the core meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and the err_chk flag.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    imem_loader_if.master bus,
    output logic         cpu_hold,
    output logic         load_done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic         err_chk,
`endif
    output logic         err_len
);
    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        err_len_q, err_len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
    logic        err_chk_q, err_chk_d;
`endif

    logic        in_ready;
    logic        we;
    logic        done_pulse;
    logic        asm_clr;
    logic        asm_valid;
    logic        word_full;
    logic [31:0] word;
    logic [15:0] len_rx;
    logic [15:0] word_cnt_inc;

    assign len_rx       = {bus.in_data, len_q[7:0]};
    assign word_cnt_inc = word_cnt_q + 16'd1;
    assign asm_valid    = (state_q == S_DATA) && bus.in_valid;

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_valid (asm_valid),
        .byte_data  (bus.in_data),
        .word       (word),
        .word_full  (word_full)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        err_len_d  = err_len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
        err_chk_d  = err_chk_q;
`endif
        in_ready   = 1'b0;
        we         = 1'b0;
        done_pulse = 1'b0;
        asm_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d    = S_LEN_LO;
                    err_len_d  = 1'b0;
                    addr_d     = BASE_ADDR;
                    word_cnt_d = '0;
                    asm_clr    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = '0;
                    err_chk_d  = 1'b0;
`endif
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    len_d[7:0] = bus.in_data;
                    state_d    = S_LEN_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = chk_q ^ bus.in_data;
`endif
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    len_d[15:8] = bus.in_data;
                    state_d     = (len_rx == 16'd0) ? S_DONE : S_DATA;
                    if (32'(len_rx) > 32'(DEPTH)) begin
                        err_len_d = 1'b1;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d       = chk_q ^ bus.in_data;
`endif
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ bus.in_data;
`endif
                    if (word_full) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Words beyond the array are still counted so the stream stays framed.
                we         = (addr_q[31:2] < 30'(DEPTH));
                addr_d     = addr_q + 32'd4;
                word_cnt_d = word_cnt_inc;
                if (word_cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data != chk_q) begin
                        err_chk_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done_pulse = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            err_len_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
            err_chk_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            err_len_q  <= err_len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
            err_chk_q  <= err_chk_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.WE_IM    = we;
    assign bus.A_IM_W   = addr_q;
    assign bus.WD_IM    = word;
    assign cpu_hold     = (state_q != S_IDLE);
    assign load_done    = done_pulse;
    assign err_len      = err_len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err_chk      = err_chk_q;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, stalled stream, empty and oversized loads, reset abort.
// Checksum cases are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst;
    logic load_start;
    logic cpu_hold;
    logic load_done;
    logic err_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic err_chk;
`endif

    imem_loader_if bus ();

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .err_chk    (err_chk),
`endif
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int done_cnt = 0;
    int rdy_viol = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  tx_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Write log, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.WE_IM) begin
            wa.push_back(bus.A_IM_W);
            wd.push_back(bus.WD_IM);
            if (bus.in_ready) rdy_viol++;
            $display("write A=%h WD=%h", bus.A_IM_W, bus.WD_IM);
        end
        if (!rst && load_done) begin
            done_cnt++;
            $display("load_done");
        end
    end

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int idle);
        bit acc = 1'b0;
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!acc) begin
            acc = bus.in_ready;
            @(negedge clk);
            t++;
            if (!acc && t > 100) begin
                check_eq("rdy_timeout", 32'(acc), 32'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic send_q(input int idle, input bit add_chk);
        logic [7:0] x = 8'h00;
        foreach (tx_q[i]) begin
            x ^= tx_q[i];
            send_byte(tx_q[i], idle);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (add_chk) send_byte(x, idle);
`else
        if (add_chk) x = 8'h00;
`endif
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!load_done && t < 60) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", 32'(load_done), 32'd1);
        @(negedge clk);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
        rdy_viol = 0;
    endtask

    task automatic load_prog(input int idle);
        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        clear_log();
        start_load();
        check_eq("hold_on", 32'(cpu_hold), 32'd1);
        send_q(idle, 1'b1);
        wait_done();
        check_eq("n_writes", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check_eq("w0_addr", wa[0], 32'h0000_0000);
            check_eq("w0_data", wd[0], 32'h00A0_0513);
            check_eq("w1_addr", wa[1], 32'h0000_0004);
            check_eq("w1_data", wd[1], 32'h00B0_0593);
        end
        check_eq("done_once", 32'(done_cnt), 32'd1);
        check_eq("hold_off", 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  x;
        rst          = 1'b1;
        load_start   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_we",    32'(bus.WE_IM),    32'd0);
        check_eq("rst_addr",  bus.A_IM_W,        32'h0);
        check_eq("rst_wd",    bus.WD_IM,         32'h0);
        check_eq("rst_hold",  32'(cpu_hold),     32'd0);
        check_eq("rst_done",  32'(load_done),    32'd0);
        check_eq("rst_errl",  32'(err_len),      32'd0);

        // Back-to-back stream, then the same stream with in_valid toggling.
        load_prog(0);
        load_prog(1);
        check_eq("rdy_in_write", 32'(rdy_viol), 32'd0);

        // Empty load.
        clear_log();
        start_load();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_eq("n0_done_lat", 32'(load_done), 32'd1);
        @(negedge clk);
        check_eq("n0_done_end", 32'(load_done), 32'd0);
        check_eq("n0_hold",     32'(cpu_hold),  32'd0);
        check_eq("n0_writes",   32'(wa.size()), 32'd0);
        check_eq("n0_errl",     32'(err_len),   32'd0);

        // Oversized load: the 258th word is counted but not written.
        clear_log();
        tx_q = '{8'h02, 8'h01};
        for (int i = 0; i < 258; i++) begin
            w = 32'h1000_0000 + 32'(i);
            for (int b = 0; b < 4; b++) tx_q.push_back(w[b*8 +: 8]);
        end
        start_load();
        send_q(0, 1'b1);
        wait_done();
        check_eq("big_writes", 32'(wa.size()), 32'd257);
        if (wa.size() == 257) begin
            check_eq("big_first_a", wa[0],   32'h0000_0000);
            check_eq("big_last_a",  wa[256], 32'h0000_0400);
            check_eq("big_last_d",  wd[256], 32'h1000_0100);
        end
        check_eq("big_errl", 32'(err_len), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("big_errchk", 32'(err_chk), 32'd0);
`endif
        start_load();
        check_eq("errl_clear", 32'(err_len), 32'd0);

        // Abort by reset after two of four data bytes.
        clear_log();
        tx_q = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_q(0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_ready", 32'(bus.in_ready), 32'd0);
        check_eq("abort_we",    32'(bus.WE_IM),    32'd0);
        check_eq("abort_addr",  bus.A_IM_W,        32'h0);
        check_eq("abort_wd",    bus.WD_IM,         32'h0);
        check_eq("abort_hold",  32'(cpu_hold),     32'd0);
        check_eq("abort_done",  32'(load_done),    32'd0);
        check_eq("abort_errl",  32'(err_len),      32'd0);

        // Fresh load after abort; write must follow the 4th byte by one cycle.
        clear_log();
        start_load();
        x = 8'h00;
        tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        foreach (tx_q[i]) begin
            x ^= tx_q[i];
            send_byte(tx_q[i], 0);
        end
        check_eq("lat_we",   32'(bus.WE_IM), 32'd1);
        check_eq("lat_addr", bus.A_IM_W,     32'h0);
        check_eq("lat_data", bus.WD_IM,      32'hDEAD_BEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
        wait_done();
        check_eq("fresh_writes", 32'(wa.size()), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Correct and wrong checksum bytes.
        clear_log();
        tx_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        start_load();
        send_q(0, 1'b0);
        wait_done();
        check_eq("chk_ok_err", 32'(err_chk),    32'd0);
        check_eq("chk_ok_wr",  32'(wa.size()),  32'd1);
        clear_log();
        tx_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
        start_load();
        send_q(0, 1'b0);
        wait_done();
        check_eq("chk_bad_err", 32'(err_chk),   32'd1);
        check_eq("chk_bad_wr",  32'(wa.size()), 32'd1);
        if (wd.size() == 1) check_eq("chk_bad_wd", wd[0], 32'h00A0_0513);
        start_load();
        check_eq("chk_clear", 32'(err_chk), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Accepts a byte stream (UART/debug bridge) under valid/ready handshake, assembles little-endian 32-bit words, and drives a synchronous write port into the instruction memory array.
- Holds the core (cpu_hold) while loading, so the fetch side only reads a fully written program.
- Sits between the host bridge and the instruction memory; the core's PC-indexed read port is untouched.

Parameters:
- DEPTH, 257, instruction memory words (indices 0..256); writes at word index >= DEPTH are suppressed.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-aligned.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- load_start  input  1  one-cycle pulse, begins a load; ignored unless IDLE
- in_valid  input  1  byte available
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- WE_IM  output  1  instruction memory write enable, one-cycle pulse per word
- A_IM_W  output  32  byte address of write (memory indexes A_IM_W >> 2)
- WD_IM  output  32  write data word
- cpu_hold  output  1  high while load in progress
- load_done  output  1  one-cycle pulse at end of load
- err_len  output  1  sticky: word count exceeded DEPTH; cleared by next accepted load_start

Behaviour:
- Reset: state IDLE. in_ready=0, WE_IM=0, A_IM_W=BASE_ADDR, WD_IM=0, cpu_hold=0, load_done=0, err_len=0, byte counter=0, word counter=0. Reset is synchronous; asserting rst mid-load aborts immediately, and partially written memory is left as is.
- Stream format: LEN_LO, LEN_HI (N = 16-bit word count, little-endian), then N×4 data bytes, each word LSB first.
- States:
  - IDLE: in_ready=0, cpu_hold=0. load_start → LEN_LO. Clear err_len and set A_IM_W=BASE_ADDR.
  - LEN_LO: in_ready=1; on transfer latch N[7:0] → LEN_HI.
  - LEN_HI: in_ready=1; on transfer latch N[15:8]. If N==0 → DONE, else DATA. Set err_len if N > DEPTH.
  - DATA: in_ready=1; on transfer shift the byte into lane byte_cnt (0..3). On the 4th byte → WRITE.
  - WRITE: in_ready=0, WE_IM=1 for exactly this cycle, with A_IM_W/WD_IM stable. WE_IM is forced 0 if word index >= DEPTH, but the word still counts. Next cycle A_IM_W += 4 and word_cnt += 1. If word_cnt == N → DONE, else DATA.
  - DONE: load_done=1 for one cycle, in_ready=0 → IDLE.
- cpu_hold=1 in every state except IDLE.
- Latency: 4th byte accepted at cycle t → WE_IM high at t+1. Minimum 5 cycles per word.
- in_valid low stalls any receive state indefinitely with no timeout. Bytes offered in IDLE, WRITE or DONE are not consumed.
- load_start while not IDLE is ignored.
- A_IM_W wraps modulo 2^32. Only the low address bits matter to the memory.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last data word, state CHK accepts one extra byte. It is compared with the XOR of all length and data bytes. A mismatch sets sticky output err_chk (reset 0, cleared on load_start). Then DONE. Port err_chk exists only when the macro is defined.
- Undefined: no CHK state and no err_chk port. The load ends after the last word.

Decomposition:
- Package imem_pkg:
  - state encoding (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE)
  - IMEM_DEPTH=257
  - BYTES_PER_WORD=4
  - LEN_BYTES=2
- Sub-module word_assembler: byte shift register plus 2-bit lane counter, outputs word and word_full. The FSM lives in imem_loader.

Test Plan:
- Load N=2, bytes 02 00 13 05 A0 00 93 05 B0 00 → WE_IM pulses: A=0x0 WD=0x00A00513, then A=0x4 WD=0x00B00593. load_done once, then cpu_hold=0.
- Same stream with in_valid toggling every other cycle → identical writes. in_ready=0 during each WRITE cycle, and no byte is lost.
- N=0 (00 00) → no WE_IM, load_done pulse 1 cycle after LEN_HI is accepted, err_len=0.
- N=258 (02 01) followed by 258 words → 257 write pulses (A up to 0x400), none at A=0x404, err_len=1. The next load_start clears it.
- rst asserted after 2 of 4 data bytes → next cycle all outputs at reset values. A fresh load then starts at BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN: stream 01 00 13 05 A0 00 plus checksum 0xB7 → err_chk=0. Checksum 0x00 → err_chk=1 and the write still occurs.
